// File: rtl/issue_if.sv
// Issue handshake between the reservation stations and the issue scheduler,
// plus the CDB ownership and divider status reported back.
interface issue_if;
  logic       int_ready;
  logic       ld_st_ready;
  logic       mult_ready;
  logic       div_ready;
  logic       int_rd;
  logic       ld_st_rd;
  logic       mult_rd;
  logic       div_rd;
  logic [1:0] cdb_owner;
  logic       cdb_owner_valid;
  logic       div_busy;

  modport master (
    output int_ready, ld_st_ready, mult_ready, div_ready,
    input  int_rd, ld_st_rd, mult_rd, div_rd,
    input  cdb_owner, cdb_owner_valid, div_busy
  );

  modport slave (
    input  int_ready, ld_st_ready, mult_ready, div_ready,
    output int_rd, ld_st_rd, mult_rd, div_rd,
    output cdb_owner, cdb_owner_valid, div_busy
  );
endinterface

// File: rtl/issue_unit.sv
// Issue scheduler: picks at most one ready station per cycle and books the CDB
// write-back slot for it so that results never collide on the bus.
module issue_unit #(
  parameter int LDST_LAT = 2,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  issue_if.slave  bus
);

  localparam int CW = $clog2(DIV_LAT + 1);

  typedef enum logic [1:0] {
    UNIT_INT  = 2'b00,
    UNIT_LDST = 2'b01,
    UNIT_MULT = 2'b10,
    UNIT_DIV  = 2'b11
  } unit_t;

  logic [DIV_LAT:0]       sched_valid;
  logic [DIV_LAT:0][1:0]  sched_id;
  logic [CW-1:0]          div_cnt;
  logic                   favor_ldst;

  logic int_ok, ldst_ok, mult_ok, div_ok;
  logic grant_int, grant_ldst, grant_mult, grant_div;

  // A unit may issue only if the CDB slot its result lands in is still free.
  always_comb begin
    int_ok  = bus.int_ready   & ~sched_valid[1];
    ldst_ok = bus.ld_st_ready & ~sched_valid[LDST_LAT];
    mult_ok = bus.mult_ready  & ~sched_valid[MULT_LAT];
    div_ok  = bus.div_ready   & ~sched_valid[DIV_LAT] & (div_cnt == '0);
  end

  always_comb begin
    grant_int  = 1'b0;
    grant_ldst = 1'b0;
    grant_mult = 1'b0;
    grant_div  = 1'b0;
    if (i_rst_n) begin
      if (div_ok)
        grant_div = 1'b1;
      else if (mult_ok)
        grant_mult = 1'b1;
      else if (favor_ldst) begin
        if (ldst_ok)     grant_ldst = 1'b1;
        else if (int_ok) grant_int  = 1'b1;
      end else begin
        if (int_ok)       grant_int  = 1'b1;
        else if (ldst_ok) grant_ldst = 1'b1;
      end
    end
  end

  // Grant writes land after the shift so they override the shifted-in entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sched_valid <= '0;
      sched_id    <= '0;
      div_cnt     <= '0;
      favor_ldst  <= 1'b0;
    end else begin
      for (int i = 0; i < DIV_LAT; i++) begin
        sched_valid[i] <= sched_valid[i+1];
        sched_id[i]    <= sched_id[i+1];
      end
      sched_valid[DIV_LAT] <= 1'b0;
      sched_id[DIV_LAT]    <= UNIT_INT;

      if (grant_int) begin
        sched_valid[0] <= 1'b1;
        sched_id[0]    <= UNIT_INT;
      end
      if (grant_ldst) begin
        sched_valid[LDST_LAT-1] <= 1'b1;
        sched_id[LDST_LAT-1]    <= UNIT_LDST;
      end
      if (grant_mult) begin
        sched_valid[MULT_LAT-1] <= 1'b1;
        sched_id[MULT_LAT-1]    <= UNIT_MULT;
      end
      if (grant_div) begin
        sched_valid[DIV_LAT-1] <= 1'b1;
        sched_id[DIV_LAT-1]    <= UNIT_DIV;
      end

      if (grant_div)
        div_cnt <= CW'(DIV_LAT - 1);
      else if (div_cnt != '0)
        div_cnt <= div_cnt - CW'(1);

      if (grant_int)
        favor_ldst <= 1'b1;
      else if (grant_ldst)
        favor_ldst <= 1'b0;
    end
  end

  assign bus.int_rd          = grant_int;
  assign bus.ld_st_rd        = grant_ldst;
  assign bus.mult_rd         = grant_mult;
  assign bus.div_rd          = grant_div;
  assign bus.cdb_owner       = sched_id[0];
  assign bus.cdb_owner_valid = sched_valid[0];
  assign bus.div_busy        = (div_cnt != '0);

endmodule

// File: tb/tb_issue_unit.sv
// Directed checks of the issue scheduler: reset, single issues, divider
// occupancy, CDB conflicts, round-robin and asynchronous reset.
module tb_issue_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  issue_if bus ();
  issue_if bus_rr ();

  issue_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  issue_unit #(.LDST_LAT(1), .MULT_LAT(4), .DIV_LAT(8)) dut_rr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_rr)
  );

  // Packed view: {int_rd, ld_st_rd, mult_rd, div_rd, owner_valid, owner[1:0], div_busy}
  logic [7:0] obs_main, obs_rr;
  assign obs_main = {bus.int_rd, bus.ld_st_rd, bus.mult_rd, bus.div_rd,
                     bus.cdb_owner_valid, bus.cdb_owner, bus.div_busy};
  assign obs_rr   = {bus_rr.int_rd, bus_rr.ld_st_rd, bus_rr.mult_rd, bus_rr.div_rd,
                     bus_rr.cdb_owner_valid, bus_rr.cdb_owner, bus_rr.div_busy};

  // req = {int, ld_st, mult, div}
  task automatic applyStimulus(input logic [3:0] req);
    {bus.int_ready, bus.ld_st_ready, bus.mult_ready, bus.div_ready}             = req;
    {bus_rr.int_ready, bus_rr.ld_st_ready, bus_rr.mult_ready, bus_rr.div_ready} = req;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task automatic runCycle(input bit use_rr, input logic [3:0] req,
                          input logic [7:0] expected, input string tag);
    applyStimulus(req);
    @(negedge clk);
    checkOutput(tag, use_rr ? obs_rr : obs_main, expected);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b1111);
    #3;
    $display("[TB] reset with all stations ready");
    checkOutput("reset_main", obs_main, 8'h00);
    checkOutput("reset_rr", obs_rr, 8'h00);
    @(negedge clk);
    checkOutput("reset_main_hold", obs_main, 8'h00);

    $display("[TB] single integer issue");
    doReset();
    runCycle(0, 4'b1000, 8'h80, "int_c0");
    runCycle(0, 4'b0000, 8'h08, "int_c1");
    runCycle(0, 4'b0000, 8'h00, "int_c2");
    runCycle(0, 4'b0000, 8'h00, "int_c3");

    $display("[TB] divider held ready");
    doReset();
    runCycle(0, 4'b0001, 8'h10, "div_c0");
    for (int c = 1; c <= 7; c++)
      runCycle(0, 4'b0001, 8'h01, $sformatf("div_c%0d", c));
    runCycle(0, 4'b0001, 8'h1E, "div_c8");
    for (int c = 9; c <= 15; c++)
      runCycle(0, 4'b0001, 8'h01, $sformatf("div_c%0d", c));
    runCycle(0, 4'b0000, 8'h0E, "div_c16");
    runCycle(0, 4'b0000, 8'h00, "div_c17");

    $display("[TB] CDB conflict");
    doReset();
    runCycle(0, 4'b0010, 8'h20, "cdb_c0");
    runCycle(0, 4'b0000, 8'h00, "cdb_c1");
    runCycle(0, 4'b1100, 8'h80, "cdb_c2");
    runCycle(0, 4'b0100, 8'h48, "cdb_c3");
    runCycle(0, 4'b0000, 8'h0C, "cdb_c4");
    runCycle(0, 4'b0000, 8'h0A, "cdb_c5");
    runCycle(0, 4'b0000, 8'h00, "cdb_c6");

    $display("[TB] round-robin int / ld_st");
    doReset();
    runCycle(1, 4'b1100, 8'h80, "rr_c0");
    runCycle(1, 4'b1100, 8'h48, "rr_c1");
    runCycle(1, 4'b1100, 8'h8A, "rr_c2");
    runCycle(1, 4'b1100, 8'h48, "rr_c3");
    runCycle(1, 4'b1100, 8'h8A, "rr_c4");
    runCycle(1, 4'b1100, 8'h48, "rr_c5");

    $display("[TB] asynchronous reset during divide");
    doReset();
    runCycle(0, 4'b0001, 8'h10, "arst_c0");
    runCycle(0, 4'b0000, 8'h01, "arst_c1");
    runCycle(0, 4'b0000, 8'h01, "arst_c2");
    applyStimulus(4'b0000);
    checkOutput("arst_c3_pre", obs_main, 8'h01);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_c3_now", obs_main, 8'h00);
    @(negedge clk);
    checkOutput("arst_c3", obs_main, 8'h00);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("arst_c4", obs_main, 8'h00);
    @(posedge clk);
    #1;
    for (int c = 5; c <= 12; c++)
      runCycle(0, 4'b0000, 8'h00, $sformatf("arst_c%0d", c));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
